echo_fb: RTL and testbench

Multichannel echo engine with a per-channel circular delay line, fractional tap gain, saturating mix and a selectable feed-forward or feedback (repeating-echo) mode. Frames of CH_NUM signed samples arrive on a valid/ready handshake. Each frame passes through a time-multiplexed datapath and leaves as one processed frame. The block sits in the audio effect chain in the same position as the existing single-tap echo, which it replaces. All logic runs on the system clock, so no separate bit-clock domain is needed.

---
 rtl/echo_fb_if.sv | 33 +++
 rtl/echo_fb.sv | 164 ++++++++++++++++
 tb/tb_echo_fb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_fb_if.sv
// echo_fb_if: frame handshake and control bundle for the echo_fb engine.
//   master : frame source (drives in_valid/in_data and the per-frame controls,
//            observes in_ready and the output strobe/frame)
//   slave  : the echo engine
// Signals: in_valid/in_ready/in_data (input frame handshake), en, fb_mode,
//          delay_num, gain (per-frame controls, latched on accept),
//          out_valid/out_data (one-cycle output strobe and processed frame).
interface echo_fb_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int CH_NUM     = 2,
  parameter int GAIN_WIDTH = 6
);
  logic                         in_valid;
  logic                         in_ready;
  logic [CH_NUM*DATA_WIDTH-1:0] in_data;
  logic                         en;
  logic                         fb_mode;
  logic [DEPTH_LOG2-1:0]        delay_num;
  logic [GAIN_WIDTH-1:0]        gain;
  logic                         out_valid;
  logic [CH_NUM*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, en, fb_mode, delay_num, gain,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, en, fb_mode, delay_num, gain,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/echo_fb.sv
// echo_fb: multichannel echo engine. Each accepted frame is processed one
// channel at a time (RD -> CALC -> WR per channel), mixing the input with a
// gain-scaled tap from a per-channel circular delay line, then presented for
// one cycle (OUT). fb_mode selects whether the delay line stores the dry
// input (feed-forward) or the mixed result (feedback, repeating echo).
// Ports:
//   clk   : system clock, rising-edge
//   reset : synchronous, active-high
//   bus   : echo_fb_if slave modport (frame handshake, controls, output)
module echo_fb #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int CH_NUM     = 2,
  parameter int GAIN_WIDTH = 6
) (
  input  logic       clk,
  input  logic       reset,
  echo_fb_if.slave   bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int AW  = CHW + DEPTH_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CH_NUM*DW-1:0]   x_q, x_d;
  logic                   en_q, en_d;
  logic                   fb_q, fb_d;
  logic [DEPTH_LOG2-1:0]  delay_q, delay_d;
  logic [GAIN_WIDTH-1:0]  gain_q, gain_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic [DEPTH_LOG2-1:0]  wp_q, wp_d;
  logic [DEPTH_LOG2-1:0]  fill_q, fill_d;
  logic [DW-1:0]          sum_q, sum_d;
  logic                   out_valid_q, out_valid_d;
  logic [CH_NUM*DW-1:0]   out_data_q, out_data_d;

  // Delay line: one RAM addressed {ch, ptr}; contents are never reset.
  logic [DW-1:0]          mem [1<<AW];
  logic [DW-1:0]          ram_rdata;
  logic                   ram_we;
  logic [DW-1:0]          ram_wdata;
  logic [AW-1:0]          rd_addr, wr_addr;

  logic [DW-1:0]          x_ch;
  logic signed [DW-1:0]   tap;
  logic signed [DW+GAIN_WIDTH:0] prod_full;
  logic [DW:0]            prod_sh;
  logic [DW:0]            sum_wide;
  logic [DW-1:0]          sum_sat;
  logic                   last_ch;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign x_ch    = x_q[ch_q*DW +: DW];
  assign last_ch = (ch_q == CHW'(CH_NUM-1));
  assign rd_addr = {ch_q, wp_q - delay_q};
  assign wr_addr = {ch_q, wp_q};

  // Tap/mix datapath, consumed in CALC. The tap is suppressed until the
  // line holds at least delay_num frames written since reset, which also
  // hides stale RAM contents.
  always_comb begin
    tap       = ((delay_q == '0) || (fill_q < delay_q)) ? '0 : $signed(ram_rdata);
    prod_full = tap * $signed({1'b0, gain_q});
    prod_sh   = (DW+1)'(prod_full >>> GAIN_WIDTH);
    sum_wide  = {x_ch[DW-1], x_ch} + prod_sh;
    if (sum_wide[DW] != sum_wide[DW-1])
      sum_sat = sum_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sum_sat = sum_wide[DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    en_d        = en_q;
    fb_d        = fb_q;
    delay_d     = delay_q;
    gain_d      = gain_q;
    ch_d        = ch_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ram_we      = 1'b0;
    ram_wdata   = fb_q ? sum_q : x_ch;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_data;
          en_d    = bus.en;
          fb_d    = bus.fb_mode;
          delay_d = bus.delay_num;
          gain_d  = bus.gain;
          ch_d    = '0;
          state_d = S_RD;
        end
      end
      S_RD:   state_d = S_CALC;
      S_CALC: begin
        sum_d   = sum_sat;
        state_d = S_WR;
      end
      S_WR: begin
        ram_we                      = 1'b1;
        out_data_d[ch_q*DW +: DW]   = en_q ? sum_q : x_ch;
        if (last_ch) begin
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_RD;
        end
      end
      S_OUT: begin
        wp_d = wp_q + DEPTH_LOG2'(1);
        if (fill_q != '1) fill_d = fill_q + DEPTH_LOG2'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      en_q        <= 1'b0;
      fb_q        <= 1'b0;
      delay_q     <= '0;
      gain_q      <= '0;
      ch_q        <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      en_q        <= en_d;
      fb_q        <= fb_d;
      delay_q     <= delay_d;
      gain_q      <= gain_d;
      ch_q        <= ch_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Synchronous RAM: read in RD (data available in CALC), write in WR.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= ram_wdata;
    if (state_q == S_RD) ram_rdata <= mem[rd_addr];
  end
endmodule

// File: tb/tb_echo_fb.sv
// tb_echo_fb: self-checking bench for echo_fb with a frame-level reference
// model (per-channel history of written values, floor-scaled tap, clamp).
module tb_echo_fb;
  localparam int DW = 16;
  localparam int DL = 4;
  localparam int CH = 2;
  localparam int GW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  echo_fb_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CH_NUM(CH), .GAIN_WIDTH(GW)) bus ();

  echo_fb #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CH_NUM(CH), .GAIN_WIDTH(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned edges = 0;
  int unsigned prev_acc = 0;
  bit          have_prev_acc = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int hist [CH][$];
  int fr_x [CH];
  int fr_y [CH];
  int y_exp[CH];
  bit fr_e, fr_fb;
  int fr_d, fr_g;

  function automatic int floor_scale(input int p);
    int den = 1 << GW;
    if (p >= 0) return p / den;
    return -((-p + den - 1) / den);
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_frame();
    int n, tap, s;
    n = hist[0].size();
    for (int c = 0; c < CH; c++) begin
      tap = (fr_d != 0 && n >= fr_d) ? hist[c][n - fr_d] : 0;
      s = clamp(fr_x[c] + floor_scale(tap * fr_g));
      hist[c].push_back(fr_fb ? s : fr_x[c]);
      y_exp[c] = fr_e ? s : fr_x[c];
    end
  endtask

  function automatic int rnd_s16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < CH; c++) hist[c].delete();
  endtask

  task automatic send_frame(input string tag, input bit hold);
    int n, cyc;
    bit rdy_hi;
    longint got;
    for (int c = 0; c < CH; c++) bus.in_data[c*DW +: DW] = DW'(fr_x[c]);
    bus.en        = fr_e;
    bus.fb_mode   = fr_fb;
    bus.delay_num = DL'(fr_d);
    bus.gain      = GW'(fr_g);
    bus.in_valid  = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) begin
      check({tag, "_ready_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (hold && have_prev_acc) check({tag, "_accept_gap"}, longint'(edges - prev_acc), 8);
    prev_acc = edges;
    have_prev_acc = 1;
    model_frame();
    // Inputs changing after acceptance must not affect the frame in flight.
    bus.in_data   = {$urandom, $urandom};
    bus.en        = 1'($urandom);
    bus.fb_mode   = 1'($urandom);
    bus.delay_num = DL'($urandom);
    bus.gain      = GW'($urandom);
    if (!hold) bus.in_valid = 1'b0;
    // cyc = cycle index relative to the acceptance cycle
    cyc = 1;
    rdy_hi = 0;
    while (bus.out_valid !== 1'b1 && cyc < 30) begin
      if (bus.in_ready) rdy_hi = 1;
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, cyc, 7);
    check({tag, "_ready_busy"}, longint'(rdy_hi | bus.in_ready), 0);
    for (int c = 0; c < CH; c++) begin
      got = longint'($signed(bus.out_data[c*DW +: DW]));
      fr_y[c] = int'(got);
      check($sformatf("%s_ch%0d", tag, c), got, y_exp[c]);
    end
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, bus.out_valid, 0);
    check({tag, "_ready_idle"}, bus.in_ready, 1);
  endtask

  task automatic set_frame(input int x0, input int x1, input bit e, input bit fb,
                           input int d, input int g);
    fr_x[0] = x0; fr_x[1] = x1; fr_e = e; fr_fb = fb; fr_d = d; fr_g = g;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0; bus.en = 1'b0; bus.fb_mode = 1'b0;
    bus.delay_num = '0; bus.gain = '0;

    do_reset();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", longint'(bus.out_data), 0);

    // Feed-forward impulse
    for (int f = 0; f <= 10; f++) begin
      set_frame(f == 0 ? 1000 : 0, f == 0 ? -1000 : 0, 1, 0, 3, 32);
      send_frame($sformatf("ff_f%0d", f), 0);
      if (f == 3) begin
        check("ff_echo_ch0", fr_y[0], 500);
        check("ff_echo_ch1", fr_y[1], -500);
      end
      if (f == 6) check("ff_no_repeat", fr_y[0], 0);
    end

    // Feedback decay
    do_reset();
    for (int f = 0; f <= 12; f++) begin
      set_frame(f == 0 ? 1000 : 0, 0, 1, 1, 3, 32);
      send_frame($sformatf("fb_f%0d", f), 0);
      if (f == 3)  check("fb_decay3", fr_y[0], 500);
      if (f == 6)  check("fb_decay6", fr_y[0], 250);
      if (f == 9)  check("fb_decay9", fr_y[0], 125);
      if (f == 12) check("fb_decay12", fr_y[0], 62);
    end

    // Saturation and rounding
    do_reset();
    for (int f = 0; f < 2; f++) begin
      set_frame(30000, -30000, 1, 0, 1, 63);
      send_frame($sformatf("sat_f%0d", f), 0);
    end
    check("sat_pos", fr_y[0], 32767);
    check("sat_neg", fr_y[1], -32768);
    do_reset();
    set_frame(-1, 1, 1, 0, 1, 32);
    send_frame("rnd_f0", 0);
    set_frame(0, 0, 1, 0, 1, 32);
    send_frame("rnd_f1", 0);
    check("rnd_neg_floor", fr_y[0], -1);
    check("rnd_pos_floor", fr_y[1], 0);

    // Fill and pointer wrap
    do_reset();
    for (int f = 0; f <= 40; f++) begin
      set_frame(f * 100, -f * 100, 1, 0, 5, 32);
      send_frame($sformatf("wrap_f%0d", f), 0);
    end
    check("wrap_f40", fr_y[0], 4000 + 1750);
    for (int f = 0; f < 4; f++) begin
      set_frame(rnd_s16(), rnd_s16(), 1, $urandom_range(0, 1), 0, 63);
      send_frame($sformatf("d0_f%0d", f), 0);
      check($sformatf("d0_dry%0d", f), fr_y[0], fr_x[0]);
    end

    // Continuous in_valid, bypass then echo
    do_reset();
    have_prev_acc = 0;
    for (int f = 0; f < 12; f++) begin
      set_frame(rnd_s16() / 2, rnd_s16() / 2, f >= 6, 0, 2, 40);
      send_frame($sformatf("hold_f%0d", f), 1);
    end
    bus.in_valid = 1'b0;

    // Reset in cycle 4 of a frame
    set_frame(1234, -4321, 1, 0, 3, 50);
    bus.in_data = {16'(-4321), 16'(1234)};
    bus.en = 1'b1; bus.fb_mode = 1'b0; bus.delay_num = 3; bus.gain = 50;
    bus.in_valid = 1'b1;
    begin
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      check("mrst_ready_wait", longint'(n < 40), 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < CH; c++) hist[c].delete();
    check("mrst_in_ready", bus.in_ready, 1);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_data", longint'(bus.out_data), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    check("mrst_no_output", seen, 0);
    for (int f = 0; f < 6; f++) begin
      set_frame(rnd_s16(), rnd_s16(), 1, 0, 3, 50);
      send_frame($sformatf("mrst_f%0d", f), 0);
    end

    // Randomized frames
    do_reset();
    for (int f = 0; f < 150; f++) begin
      int x0, x1;
      x0 = (f % 17 == 0) ? 32767 : rnd_s16();
      x1 = (f % 19 == 0) ? -32768 : rnd_s16();
      set_frame(x0, x1, 1'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 63));
      send_frame($sformatf("rand_f%0d", f), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
